muldiv_sequencer: RTL and testbench



---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/muldiv_if.sv | 31 +++
 rtl/muldiv_step.sv | 37 +++
 rtl/muldiv_sequencer.sv | 141 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the mult/div engine
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    // Cycles from the start-sampling edge to the done cycle of a normal operation.
    function automatic int latency(input int width = DEFAULT_WIDTH);
        return width + 2;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - start/busy/done handshake and result bus of the mult/div engine
// master: control unit (drives start, op, a, b)
// slave:  muldiv_sequencer (drives busy, done, load_hi, load_lo, hi_out, lo_out, div_zero)
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             load_hi;
    logic             load_lo;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             div_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, load_hi, load_lo, hi_out, lo_out, div_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, load_hi, load_lo, hi_out, lo_out, div_zero
    );

endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add (mult) or restoring shift-subtract (div) iteration
// op:       OP_MULT / OP_DIV
// acc_in:   accumulator (mult: partial product; div: {remainder, quotient})
// operand:  multiplicand magnitude (mult) or divisor magnitude (div)
// shift_in: next multiplier bit (mult) or next dividend bit (div), MSB first
// acc_out:  accumulator after this iteration
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               op,
    input  logic [2*WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0]   operand,
    input  logic               shift_in,
    output logic [2*WIDTH-1:0] acc_out
);

    // Remainder shifted left with the next dividend bit; one extra bit so the
    // compare against the divisor never overflows.
    logic [WIDTH:0] trial;

    always_comb begin
        acc_out = '0;
        trial   = {acc_in[2*WIDTH-1:WIDTH], shift_in};
        if (op == OP_MULT) begin
            acc_out = {acc_in[2*WIDTH-2:0], 1'b0}
                    + (shift_in ? {{WIDTH{1'b0}}, operand} : '0);
        end else if (trial >= {1'b0, operand}) begin
            // Difference is below the divisor, so it fits in WIDTH bits.
            acc_out = {trial[WIDTH-1:0] - operand, acc_in[WIDTH-2:0], 1'b1};
        end else begin
            acc_out = {trial[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative signed mult/div engine with its own sequencer
// clk:   system clock, rising edge
// reset: synchronous, active-low
// bus:   muldiv_if slave (start/op/a/b in; busy/done/load_hi/load_lo/hi_out/lo_out/div_zero out)
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);

    state_t             state_q, state_d;
    logic               op_q;
    logic               sign_a_q;
    logic               sign_b_q;
    logic               dz_q;
    logic [WIDTH-1:0]   mag_a_q;     // shifted out MSB first, one bit per RUN cycle
    logic [WIDTH-1:0]   mag_b_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_step;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               start_dz;

    // |0x80000000| wraps back to 0x80000000, which is the correct unsigned magnitude.
    assign a_mag    = bus.a[WIDTH-1] ? -bus.a : bus.a;
    assign b_mag    = bus.b[WIDTH-1] ? -bus.b : bus.b;
    assign start_dz = (bus.op == OP_DIV) && (bus.b == '0);

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op       (op_q),
        .acc_in   (acc_q),
        .operand  (mag_b_q),
        .shift_in (mag_a_q[WIDTH-1]),
        .acc_out  (acc_step)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.load_hi  = 1'b0;
        bus.load_lo  = 1'b0;
        bus.div_zero = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = start_dz ? DONE : RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                bus.busy = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                bus.busy     = 1'b1;
                bus.done     = 1'b1;
                bus.load_hi  = !dz_q;
                bus.load_lo  = !dz_q;
                bus.div_zero = dz_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q     <= OP_MULT;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            dz_q     <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        op_q     <= bus.op;
                        sign_a_q <= bus.a[WIDTH-1];
                        sign_b_q <= bus.b[WIDTH-1];
                        mag_a_q  <= a_mag;
                        mag_b_q  <= b_mag;
                        dz_q     <= start_dz;
                        cnt_q    <= CNT_W'(WIDTH - 1);
                        if (!start_dz) begin
                            acc_q <= '0;
                        end
                    end
                end
                RUN: begin
                    acc_q   <= acc_step;
                    mag_a_q <= {mag_a_q[WIDTH-2:0], 1'b0};
                    cnt_q   <= cnt_q - CNT_W'(1);
                end
                FIX: begin
                    if (op_q == OP_MULT) begin
                        {hi_q, lo_q} <= (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
                    end else begin
                        // Truncating division: remainder follows the dividend's sign.
                        lo_q <= (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                        hi_q <= sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hi_out = hi_q;
    assign bus.lo_out = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int W   = 32;
    localparam int LAT = latency(W);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(W)) bus();

    muldiv_sequencer #(
        .WIDTH (W),
        .CNT_W (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference result {div_zero, hi, lo} from plain signed arithmetic.
    function automatic logic [2*W:0] model_result(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy, p, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (o == OP_MULT) begin
            p = sx * sy;
            return {1'b0, p[63:0]};
        end
        if (y == '0) begin
            return {1'b1, 64'h0};
        end
        q = sx / sy;
        r = sx % sy;
        return {1'b0, r[31:0], q[31:0]};
    endfunction

    // Transaction-level model: cycles remaining until idle, pending and visible results.
    int           m_remain = 0;
    logic         m_pend_dz = 1'b0;
    logic [W-1:0] m_pend_hi = '0;
    logic [W-1:0] m_pend_lo = '0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic [2*W:0] m_next;

    always_comb m_next = model_result(bus.op, bus.a, bus.b);

    always @(posedge clk) begin
        if (!reset) begin
            m_remain  <= 0;
            m_pend_dz <= 1'b0;
            m_hi      <= '0;
            m_lo      <= '0;
        end else if (m_remain == 0) begin
            if (bus.start) begin
                m_pend_dz <= m_next[2*W];
                m_pend_hi <= m_next[2*W-1:W];
                m_pend_lo <= m_next[W-1:0];
                m_remain  <= m_next[2*W] ? 1 : LAT;
            end
        end else begin
            if (m_remain == 2 && !m_pend_dz) begin
                m_hi <= m_pend_hi;
                m_lo <= m_pend_lo;
            end
            m_remain <= m_remain - 1;
        end
    end

    logic chk_en   = 1'b0;
    int   done_cnt = 0;

    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            done_cnt <= done_cnt + 1;
        end
        if (chk_en) begin
            check("cyc_busy",     64'(bus.busy),     64'(m_remain != 0));
            check("cyc_done",     64'(bus.done),     64'(m_remain == 1));
            check("cyc_load_hi",  64'(bus.load_hi),  64'(m_remain == 1 && !m_pend_dz));
            check("cyc_load_lo",  64'(bus.load_lo),  64'(m_remain == 1 && !m_pend_dz));
            check("cyc_div_zero", 64'(bus.div_zero), 64'(m_remain == 1 && m_pend_dz));
            check("cyc_hi_out",   64'(bus.hi_out),   64'(m_hi));
            check("cyc_lo_out",   64'(bus.lo_out),   64'(m_lo));
        end
    end

    task automatic wait_done(output time tn);
        for (int i = 0; i < 100 && bus.done !== 1'b1; i++) @(negedge clk);
        tn = $time;
    endtask

    task automatic run_op(input string nm, input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz);
        time t0, tn;
        int  lat;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        @(posedge clk);
        t0 = $time;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(tn);
        lat = edz ? 1 : LAT;
        check({nm, "_latency"},  64'(tn - t0),       64'((lat - 1) * 10 + 5));
        check({nm, "_hi"},       64'(bus.hi_out),    64'(eh));
        check({nm, "_lo"},       64'(bus.lo_out),    64'(el));
        check({nm, "_div_zero"}, 64'(bus.div_zero),  64'(edz));
        check({nm, "_load"},     64'(bus.load_hi & bus.load_lo), 64'(!edz));
        @(negedge clk);
        check({nm, "_busy_after"}, 64'(bus.busy), 64'(0));
    endtask

    initial begin
        time t0, tn1, tn2;
        int  d0;
        bus.start = 1'b0;
        bus.op    = OP_MULT;
        bus.a     = '0;
        bus.b     = '0;
        reset     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("reset_busy", 64'(bus.busy),   64'(0));
        check("reset_done", 64'(bus.done),   64'(0));
        check("reset_hi",   64'(bus.hi_out), 64'(0));
        check("reset_lo",   64'(bus.lo_out), 64'(0));
        @(negedge clk);
        reset = 1'b1;

        run_op("mul_7x6",     OP_MULT, 32'd7,        32'd6,        32'h00000000, 32'h0000002A, 1'b0);
        run_op("mul_m3x5",    OP_MULT, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
        run_op("div_m7d2",    OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op("div_100dm7",  OP_DIV,  32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0);
        run_op("mul_min_min", OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
        run_op("div_ovf",     OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        run_op("div_zero",    OP_DIV,  32'd123,      32'd0,        32'h00000000, 32'h80000000, 1'b1);

        // Start held high; a div request shows up mid-operation and must be ignored.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MULT;
        bus.a     = 32'd3;
        bus.b     = 32'd4;
        @(posedge clk);
        t0 = $time;
        repeat (10) @(negedge clk);
        bus.op = OP_DIV;
        bus.a  = 32'd100;
        bus.b  = 32'd7;
        @(negedge clk);
        bus.op = OP_MULT;
        bus.a  = 32'd3;
        bus.b  = 32'd4;
        wait_done(tn1);
        check("hold_latency", 64'(tn1 - t0),     64'((LAT - 1) * 10 + 5));
        check("hold_lo",      64'(bus.lo_out),   64'(12));
        check("hold_hi",      64'(bus.hi_out),   64'(0));
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(tn2);
        check("hold_throughput", 64'(tn2 - tn1), 64'((W + 3) * 10));
        check("hold_lo2",        64'(bus.lo_out), 64'(12));
        @(negedge clk);

        // Reset mid-operation abandons the operation with no strobes.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MULT;
        bus.a     = 32'd9;
        bus.b     = 32'd9;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        check("rst_busy_before", 64'(bus.busy), 64'(1));
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(bus.busy),   64'(0));
        check("rst_done", 64'(bus.done),   64'(0));
        check("rst_hi",   64'(bus.hi_out), 64'(0));
        check("rst_lo",   64'(bus.lo_out), 64'(0));
        reset = 1'b1;
        d0 = done_cnt;
        repeat (50) @(negedge clk);
        check("rst_no_done", 64'(done_cnt - d0), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
